// File: rtl/instr_register_exec.sv
// Instruction store with a built-in execution engine: single-cycle arithmetic and iterative
// DIV/MOD/POW. Define INSTR_REG_ERR_EN to add per-entry error flags and the rd_err_o port.
module instr_register_exec #(
  parameter int unsigned  OP_WIDTH = 32,
  parameter int unsigned  DEPTH    = 32,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [3:0]                   wr_opc_i,
  input  logic signed [OP_WIDTH-1:0]   wr_op_a_i,
  input  logic signed [OP_WIDTH-1:0]   wr_op_b_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic [3:0]                   rd_opc_o,
  output logic signed [OP_WIDTH-1:0]   rd_op_a_o,
  output logic signed [OP_WIDTH-1:0]   rd_op_b_o,
  output logic signed [2*OP_WIDTH-1:0] rd_result_o,
  output logic                         rd_done_o,
`ifdef INSTR_REG_ERR_EN
  output logic                         rd_err_o,
`endif
  output logic                         busy_o,
  output logic                         wb_valid_o,
  output logic [ADDR_W-1:0]            wb_addr_o
);

  localparam int unsigned ResW = 2 * OP_WIDTH;
  localparam int unsigned CntW = $clog2(OP_WIDTH + 1);

  localparam logic [3:0] OpZero  = 4'd0;
  localparam logic [3:0] OpPassA = 4'd1;
  localparam logic [3:0] OpPassB = 4'd2;
  localparam logic [3:0] OpAdd   = 4'd3;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpMult  = 4'd5;
  localparam logic [3:0] OpDiv   = 4'd6;
  localparam logic [3:0] OpMod   = 4'd7;
  localparam logic [3:0] OpPow   = 4'd8;

  typedef enum logic [1:0] {StIdle, StCalc, StIter, StWb} state_e;

  state_e              state_q;
  logic [3:0]          opc_mem  [DEPTH];
  logic [OP_WIDTH-1:0] op_a_mem [DEPTH];
  logic [OP_WIDTH-1:0] op_b_mem [DEPTH];
  logic [ResW-1:0]     res_mem  [DEPTH];
  // Entries not written since reset read as all-zero, which stands in for clearing the arrays.
  logic [DEPTH-1:0]    live_q;
  logic [DEPTH-1:0]    done_q;

  logic [3:0]          opc_q;
  logic [OP_WIDTH-1:0] op_a_q, op_b_q;
  logic [ADDR_W-1:0]   addr_q, wb_addr_q;
  logic [CntW-1:0]     cnt_q;
  logic [OP_WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [ResW-1:0]     acc_q, base_q, res_q;
  logic                wb_valid_q;

  logic [3:0]          rd_opc_q;
  logic [OP_WIDTH-1:0] rd_op_a_q, rd_op_b_q;
  logic [ResW-1:0]     rd_res_q;
  logic                rd_done_q;

`ifdef INSTR_REG_ERR_EN
  logic [DEPTH-1:0]    err_mem_q;
  logic                err_q;
  logic                rd_err_q;
  assign rd_err_o = rd_err_q;
`endif

  logic accept;
  assign wr_ready_o = !reset_i && (state_q == StIdle);
  assign busy_o     = !reset_i && (state_q != StIdle);
  assign accept     = wr_valid_i && wr_ready_o;

  assign rd_opc_o    = rd_opc_q;
  assign rd_op_a_o   = rd_op_a_q;
  assign rd_op_b_o   = rd_op_b_q;
  assign rd_result_o = rd_res_q;
  assign rd_done_o   = rd_done_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_addr_o   = wb_addr_q;

  logic [OP_WIDTH-1:0] wr_a_mag, wr_b_mag;
  logic [ResW-1:0]     a_ext, b_ext;
  assign wr_a_mag = wr_op_a_i[OP_WIDTH-1] ? -wr_op_a_i : wr_op_a_i;
  assign wr_b_mag = wr_op_b_i[OP_WIDTH-1] ? -wr_op_b_i : wr_op_b_i;
  assign a_ext    = {{OP_WIDTH{op_a_q[OP_WIDTH-1]}}, op_a_q};
  assign b_ext    = {{OP_WIDTH{op_b_q[OP_WIDTH-1]}}, op_b_q};

  // One iteration: restoring division on magnitudes, or right-to-left square-and-multiply
  // with the exponent shifting out of quo_q.
  logic [OP_WIDTH:0]   rem_sh;
  logic                rem_ge;
  logic [OP_WIDTH-1:0] rem_step, quo_step;
  logic [ResW-1:0]     acc_step, base_step;
  always_comb begin
    rem_sh    = {rem_q, quo_q[OP_WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, dvs_q};
    rem_step  = rem_ge ? OP_WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[OP_WIDTH-1:0];
    quo_step  = (opc_q == OpPow) ? (quo_q >> 1) : {quo_q[OP_WIDTH-2:0], rem_ge};
    acc_step  = quo_q[0] ? acc_q * base_q : acc_q;
    base_step = base_q * base_q;
  end

  logic [ResW-1:0] raw_res, fin_res, quo_ext, rem_ext;
  logic            fin_err;
  always_comb begin
    quo_ext = {{OP_WIDTH{1'b0}}, quo_q};
    rem_ext = {{OP_WIDTH{1'b0}}, rem_q};
    raw_res = '0;
    fin_err = 1'b0;
    case (opc_q)
      OpZero:  raw_res = '0;
      OpPassA: raw_res = a_ext;
      OpPassB: raw_res = b_ext;
      OpAdd:   raw_res = a_ext + b_ext;
      OpSub:   raw_res = a_ext - b_ext;
      OpMult:  raw_res = a_ext * b_ext;
      OpDiv: begin
        fin_err = (op_b_q == '0);
        raw_res = (op_a_q[OP_WIDTH-1] ^ op_b_q[OP_WIDTH-1]) ? -quo_ext : quo_ext;
      end
      OpMod: begin
        fin_err = (op_b_q == '0);
        raw_res = op_a_q[OP_WIDTH-1] ? -rem_ext : rem_ext;
      end
      OpPow: begin
        fin_err = op_b_q[OP_WIDTH-1];
        raw_res = acc_q;
      end
      default: fin_err = 1'b1;
    endcase
    fin_res = fin_err ? '0 : raw_res;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      live_q     <= '0;
      done_q     <= '0;
      opc_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      acc_q      <= '0;
      base_q     <= '0;
      res_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      rd_opc_q   <= '0;
      rd_op_a_q  <= '0;
      rd_op_b_q  <= '0;
      rd_res_q   <= '0;
      rd_done_q  <= 1'b0;
`ifdef INSTR_REG_ERR_EN
      err_mem_q  <= '0;
      err_q      <= 1'b0;
      rd_err_q   <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      rd_opc_q   <= live_q[rd_addr_i] ? opc_mem[rd_addr_i]  : '0;
      rd_op_a_q  <= live_q[rd_addr_i] ? op_a_mem[rd_addr_i] : '0;
      rd_op_b_q  <= live_q[rd_addr_i] ? op_b_mem[rd_addr_i] : '0;
      rd_res_q   <= live_q[rd_addr_i] ? res_mem[rd_addr_i]  : '0;
      rd_done_q  <= done_q[rd_addr_i];
`ifdef INSTR_REG_ERR_EN
      rd_err_q   <= err_mem_q[rd_addr_i];
`endif
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            opc_mem[wr_addr_i]  <= wr_opc_i;
            op_a_mem[wr_addr_i] <= wr_op_a_i;
            op_b_mem[wr_addr_i] <= wr_op_b_i;
            res_mem[wr_addr_i]  <= '0;
            live_q[wr_addr_i]   <= 1'b1;
            done_q[wr_addr_i]   <= 1'b0;
`ifdef INSTR_REG_ERR_EN
            err_mem_q[wr_addr_i] <= 1'b0;
`endif
            opc_q   <= wr_opc_i;
            op_a_q  <= wr_op_a_i;
            op_b_q  <= wr_op_b_i;
            addr_q  <= wr_addr_i;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= (wr_opc_i == OpPow) ? wr_op_b_i : wr_a_mag;
            dvs_q   <= wr_b_mag;
            acc_q   <= ResW'(1);
            base_q  <= {{OP_WIDTH{wr_op_a_i[OP_WIDTH-1]}}, wr_op_a_i};
            state_q <= (wr_opc_i inside {OpDiv, OpMod, OpPow}) ? StIter : StCalc;
          end
        end
        StCalc: begin
          res_q   <= fin_res;
`ifdef INSTR_REG_ERR_EN
          err_q   <= fin_err;
`endif
          state_q <= StWb;
        end
        StIter: begin
          // OP_WIDTH step cycles, then one cycle to apply signs and latch the result.
          if (cnt_q == CntW'(OP_WIDTH)) begin
            res_q   <= fin_res;
`ifdef INSTR_REG_ERR_EN
            err_q   <= fin_err;
`endif
            state_q <= StWb;
          end else begin
            cnt_q  <= cnt_q + CntW'(1);
            rem_q  <= rem_step;
            quo_q  <= quo_step;
            acc_q  <= acc_step;
            base_q <= base_step;
          end
        end
        StWb: begin
          res_mem[addr_q] <= res_q;
          done_q[addr_q]  <= 1'b1;
`ifdef INSTR_REG_ERR_EN
          err_mem_q[addr_q] <= err_q;
`endif
          wb_valid_q <= 1'b1;
          wb_addr_q  <= addr_q;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_register_exec.sv
// Directed bench for instr_register_exec: vector table plus hand-written multi-cycle sequences.
// Compile with INSTR_REG_ERR_EN to also check rd_err_o.
module tb_instr_register_exec;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned NV = 20;

  typedef struct {
    logic [4:0]  addr;
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_opc;
  logic [31:0] wr_op_a, wr_op_b;
  logic [4:0]  rd_addr;
  logic [3:0]  rd_opc;
  logic [31:0] rd_op_a, rd_op_b;
  logic [63:0] rd_result;
  logic        rd_done;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_addr;
`ifdef INSTR_REG_ERR_EN
  logic        rd_err;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs [NV];

  instr_register_exec #(.OP_WIDTH(W), .DEPTH(D)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .wr_addr_i  (wr_addr),
    .wr_opc_i   (wr_opc),
    .wr_op_a_i  (wr_op_a),
    .wr_op_b_i  (wr_op_b),
    .rd_addr_i  (rd_addr),
    .rd_opc_o   (rd_opc),
    .rd_op_a_o  (rd_op_a),
    .rd_op_b_o  (rd_op_b),
    .rd_result_o(rd_result),
    .rd_done_o  (rd_done),
`ifdef INSTR_REG_ERR_EN
    .rd_err_o   (rd_err),
`endif
    .busy_o     (busy),
    .wb_valid_o (wb_valid),
    .wb_addr_o  (wb_addr)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] ad, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!wr_ready && w < 100) begin
      tick();
      w++;
    end
    chk("issue_ready", {63'd0, wr_ready}, 64'd1);
    wr_valid = 1'b1;
    wr_addr  = ad;
    wr_opc   = op;
    wr_op_a  = a;
    wr_op_b  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_wb(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!wb_valid && lat < 100);
  endtask

  initial begin
    int lat;
    int lo;
    int pulses;

    vecs[0]  = '{addr: 5'd3,  opc: 4'd3,  a: 32'd5,         b: 32'hFFFF_FFF9,
                 res: 64'hFFFF_FFFF_FFFF_FFFE, err: 1'b0};
    vecs[1]  = '{addr: 5'd4,  opc: 4'd5,  a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF,
                 res: 64'h3FFF_FFFF_0000_0001, err: 1'b0};
    vecs[2]  = '{addr: 5'd6,  opc: 4'd4,  a: 32'hFFFF_FFFB, b: 32'd7,
                 res: 64'hFFFF_FFFF_FFFF_FFF4, err: 1'b0};
    vecs[3]  = '{addr: 5'd7,  opc: 4'd1,  a: 32'hFFFF_FFFF, b: 32'd9,
                 res: 64'hFFFF_FFFF_FFFF_FFFF, err: 1'b0};
    vecs[4]  = '{addr: 5'd8,  opc: 4'd2,  a: 32'd1,         b: 32'h8000_0000,
                 res: 64'hFFFF_FFFF_8000_0000, err: 1'b0};
    vecs[5]  = '{addr: 5'd9,  opc: 4'd0,  a: 32'd1,         b: 32'd2,
                 res: 64'd0, err: 1'b0};
    vecs[6]  = '{addr: 5'd10, opc: 4'd7,  a: 32'hFFFF_FFEF, b: 32'd5,
                 res: 64'hFFFF_FFFF_FFFF_FFFE, err: 1'b0};
    vecs[7]  = '{addr: 5'd11, opc: 4'd8,  a: 32'd3,         b: 32'd5,
                 res: 64'd243, err: 1'b0};
    vecs[8]  = '{addr: 5'd12, opc: 4'd8,  a: 32'd2,         b: 32'd63,
                 res: 64'h8000_0000_0000_0000, err: 1'b0};
    vecs[9]  = '{addr: 5'd13, opc: 4'd8,  a: 32'd2,         b: 32'd64,
                 res: 64'd0, err: 1'b0};
    vecs[10] = '{addr: 5'd14, opc: 4'd8,  a: 32'd7,         b: 32'd0,
                 res: 64'd1, err: 1'b0};
    vecs[11] = '{addr: 5'd15, opc: 4'd8,  a: 32'd4,         b: 32'hFFFF_FFFF,
                 res: 64'd0, err: 1'b1};
    vecs[12] = '{addr: 5'd16, opc: 4'd6,  a: 32'd10,        b: 32'd0,
                 res: 64'd0, err: 1'b1};
    vecs[13] = '{addr: 5'd17, opc: 4'd12, a: 32'd3,         b: 32'd4,
                 res: 64'd0, err: 1'b1};
    vecs[14] = '{addr: 5'd18, opc: 4'd6,  a: 32'd100,       b: 32'hFFFF_FFF9,
                 res: 64'hFFFF_FFFF_FFFF_FFF2, err: 1'b0};
    vecs[15] = '{addr: 5'd19, opc: 4'd7,  a: 32'd17,        b: 32'hFFFF_FFFB,
                 res: 64'd2, err: 1'b0};
    vecs[16] = '{addr: 5'd20, opc: 4'd8,  a: 32'hFFFF_FFFD, b: 32'd3,
                 res: 64'hFFFF_FFFF_FFFF_FFE5, err: 1'b0};
    vecs[17] = '{addr: 5'd21, opc: 4'd7,  a: 32'd9,         b: 32'd0,
                 res: 64'd0, err: 1'b1};
    vecs[18] = '{addr: 5'd22, opc: 4'd3,  a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF,
                 res: 64'h0000_0000_FFFF_FFFE, err: 1'b0};
    vecs[19] = '{addr: 5'd23, opc: 4'd8,  a: 32'd0,         b: 32'd0,
                 res: 64'd1, err: 1'b0};

    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_opc   = '0;
    wr_op_a  = '0;
    wr_op_b  = '0;
    rd_addr  = '0;

    // Reset behaviour and cleared entries
    tick();
    chk("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_wr_ready", {63'd0, wr_ready}, 64'd1);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    for (int k = 0; k < 2; k++) begin
      rd_addr = (k == 0) ? 5'd0 : 5'd31;
      tick();
      chk($sformatf("rst_rd%0d_opc", rd_addr), {60'd0, rd_opc}, 64'd0);
      chk($sformatf("rst_rd%0d_ops", rd_addr), {rd_op_a, rd_op_b}, 64'd0);
      chk($sformatf("rst_rd%0d_result", rd_addr), rd_result, 64'd0);
      chk($sformatf("rst_rd%0d_done", rd_addr), {63'd0, rd_done}, 64'd0);
    end

    // Vector table
    for (int i = 0; i < int'(NV); i++) begin
      issue(vecs[i].addr, vecs[i].opc, vecs[i].a, vecs[i].b);
      wait_wb(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat),
          (vecs[i].opc inside {4'd6, 4'd7, 4'd8}) ? 64'(W + 2) : 64'd2);
      chk($sformatf("v%0d_wb_addr", i), {59'd0, wb_addr}, {59'd0, vecs[i].addr});
      chk($sformatf("v%0d_ready_at_wb", i), {63'd0, wr_ready}, 64'd1);
      rd_addr = vecs[i].addr;
      tick();
      chk($sformatf("v%0d_result", i), rd_result, vecs[i].res);
      chk($sformatf("v%0d_done", i), {63'd0, rd_done}, 64'd1);
      chk($sformatf("v%0d_opc", i), {60'd0, rd_opc}, {60'd0, vecs[i].opc});
      chk($sformatf("v%0d_ops", i), {rd_op_a, rd_op_b}, {vecs[i].a, vecs[i].b});
`ifdef INSTR_REG_ERR_EN
      chk($sformatf("v%0d_err", i), {63'd0, rd_err}, {63'd0, vecs[i].err});
`endif
    end

    // Rewrite of a done entry; reads see pre-edge contents
    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_opc   = 4'd4;
    wr_op_a  = 32'hFFFF_FFFB;
    wr_op_b  = 32'd7;
    rd_addr  = 5'd3;
    tick();
    wr_valid = 1'b0;
    chk("rewr_pre_done", {63'd0, rd_done}, 64'd1);
    chk("rewr_pre_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("rewr_cleared_done", {63'd0, rd_done}, 64'd0);
    chk("rewr_cleared_result", rd_result, 64'd0);
    chk("rewr_new_opc", {60'd0, rd_opc}, 64'd4);
    tick();
    chk("rewr_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("rewr_commit_edge_done", {63'd0, rd_done}, 64'd0);
    tick();
    chk("rewr_wb_pulse_end", {63'd0, wb_valid}, 64'd0);
    chk("rewr_done", {63'd0, rd_done}, 64'd1);
    chk("rewr_result", rd_result, 64'hFFFF_FFFF_FFFF_FFF4);

    // DIV with wr_valid held high carrying a second instruction
    rd_addr  = 5'd5;
    wr_valid = 1'b1;
    wr_addr  = 5'd5;
    wr_opc   = 4'd6;
    wr_op_a  = 32'hFFFF_FFEF;
    wr_op_b  = 32'd5;
    tick();
    wr_addr = 5'd25;
    wr_opc  = 4'd3;
    wr_op_a = 32'd1;
    wr_op_b = 32'd1;
    lo = 0;
    while (!wr_ready && lo < 60) begin
      lo++;
      tick();
    end
    chk("hold_busy_cycles", 64'(lo), 64'(W + 2));
    chk("hold_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("hold_wb_addr", {59'd0, wb_addr}, 64'd5);
    chk("hold_commit_edge_done", {63'd0, rd_done}, 64'd0);
    tick();
    wr_valid = 1'b0;
    chk("hold_div_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("hold_div_done", {63'd0, rd_done}, 64'd1);
    chk("hold_second_accepted", {63'd0, busy}, 64'd1);
    wait_wb(lat);
    chk("hold_second_latency", 64'(lat), 64'd2);
    chk("hold_second_wb_addr", {59'd0, wb_addr}, 64'd25);
    rd_addr = 5'd25;
    tick();
    chk("hold_second_result", rd_result, 64'd2);

    // Reset in the middle of a DIV
    issue(5'd26, 4'd6, 32'd50, 32'd3);
    repeat (10) tick();
    chk("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    reset  = 1'b0;
    pulses = 0;
    repeat (40) begin
      tick();
      if (wb_valid) pulses++;
    end
    chk("mid_rst_no_wb", 64'(pulses), 64'd0);
    rd_addr = 5'd26;
    tick();
    chk("mid_rst_opc", {60'd0, rd_opc}, 64'd0);
    chk("mid_rst_ops", {rd_op_a, rd_op_b}, 64'd0);
    chk("mid_rst_result", rd_result, 64'd0);
    chk("mid_rst_done", {63'd0, rd_done}, 64'd0);
    rd_addr = 5'd4;
    tick();
    chk("mid_rst_other_entry", rd_result, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
